// File: rtl/tdc_acq_sequencer_pkg.sv
// Shared state encoding and constants for the TDC acquisition sequencer.
package tdc_acq_sequencer_pkg;

  localparam int         DATA_W_DEFAULT = 32;
  localparam logic [7:0] HDR_SYNC       = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SETTLE,
    ST_HDR0,
    ST_HDR1,
    ST_POP,
    ST_WAIT,
    ST_SEND
  } seq_state_t;

endpackage

// File: rtl/tdc_acq_sequencer_tx_word_serializer.sv
// Loads one FIFO word and emits it MSB-first as DATA_W/8 bytes over a valid/ready
// handshake; done pulses in the cycle the final byte is accepted.
module tx_word_serializer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              ready,
  output logic              valid,
  output logic [7:0]        data,
  output logic              done
);

  localparam int NUM_BYTES = DATA_W / 8;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  logic [DATA_W-1:0] shreg_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              valid_reg;
  logic              last_byte;

  assign last_byte = (idx_reg == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_reg <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      shreg_reg <= word;
      idx_reg   <= '0;
      valid_reg <= 1'b1;
    end else if (valid_reg && ready) begin
      // Shifting the whole word out leaves the register at zero, so data idles low.
      shreg_reg <= shreg_reg << 8;
      idx_reg   <= idx_reg + IDX_W'(1);
      if (last_byte) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign valid = valid_reg;
  assign data  = shreg_reg[DATA_W-1 -: 8];
  assign done  = valid_reg && ready && last_byte;

endmodule

// File: rtl/tdc_acq_sequencer.sv
// TDC acquisition run sequencer: captures NUM_HITS timestamps into the hit FIFO, then drains
// them to the UART MSB-first. Define TDC_SEQ_HEADER_EN to prefix each read with 0xA5, count.
module tdc_acq_sequencer
  import tdc_acq_sequencer_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int NUM_HITS    = 32,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_write,
  input  logic              start_read,
  input  logic              hit_valid,
  input  logic [DATA_W-1:0] hit_data,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_rd_en,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              led_write_stage,
  output logic              led_read_stage,
  output logic              led_write_err,
  output logic              led_read_err
);

  localparam int CNT_W = $clog2(NUM_HITS + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int ST_W  = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] NUM_HITS_C  = CNT_W'(NUM_HITS);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE_CYC - 1);

  seq_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  hit_cnt_reg, hit_cnt_next;
  logic [CNT_W-1:0]  rd_cnt_reg, rd_cnt_next;
  logic [CNT_W-1:0]  ww_reg, ww_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic [ST_W-1:0]   settle_cnt_reg, settle_cnt_next;
  logic              wr_err_reg, wr_err_next;
  logic              rd_err_reg, rd_err_next;
  logic              fifo_wr_en_reg, fifo_wr_en_next;
  logic [DATA_W-1:0] fifo_din_reg, fifo_din_next;

  logic              ser_load, ser_valid, ser_done;
  logic [7:0]        ser_data;
  logic              hdr_valid;
  logic [7:0]        hdr_data;

  tx_word_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ser_load),
    .word  (fifo_dout),
    .ready (tx_ready),
    .valid (ser_valid),
    .data  (ser_data),
    .done  (ser_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      hit_cnt_reg    <= '0;
      rd_cnt_reg     <= '0;
      ww_reg         <= '0;
      to_cnt_reg     <= '0;
      settle_cnt_reg <= '0;
      wr_err_reg     <= 1'b0;
      rd_err_reg     <= 1'b0;
      fifo_wr_en_reg <= 1'b0;
      fifo_din_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      hit_cnt_reg    <= hit_cnt_next;
      rd_cnt_reg     <= rd_cnt_next;
      ww_reg         <= ww_next;
      to_cnt_reg     <= to_cnt_next;
      settle_cnt_reg <= settle_cnt_next;
      wr_err_reg     <= wr_err_next;
      rd_err_reg     <= rd_err_next;
      fifo_wr_en_reg <= fifo_wr_en_next;
      fifo_din_reg   <= fifo_din_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hit_cnt_next    = hit_cnt_reg;
    rd_cnt_next     = rd_cnt_reg;
    ww_next         = ww_reg;
    to_cnt_next     = to_cnt_reg;
    settle_cnt_next = settle_cnt_reg;
    wr_err_next     = wr_err_reg;
    rd_err_next     = rd_err_reg;
    fifo_wr_en_next = 1'b0;
    fifo_din_next   = fifo_din_reg;
    fifo_rd_en      = 1'b0;
    ser_load        = 1'b0;
    hdr_valid       = 1'b0;
    hdr_data        = 8'h00;
    case (state_reg)
      ST_IDLE: begin
        if (start_write) begin
          state_next   = ST_WRITE;
          hit_cnt_next = '0;
          to_cnt_next  = '0;
          wr_err_next  = 1'b0;
        end else if (start_read) begin
          state_next      = ST_SETTLE;
          rd_cnt_next     = '0;
          settle_cnt_next = '0;
          rd_err_next     = 1'b0;
        end
      end
      ST_WRITE: begin
        if (hit_valid && fifo_full) begin
          wr_err_next = 1'b1;
          ww_next     = hit_cnt_reg;
          state_next  = ST_IDLE;
        end else if (hit_valid) begin
          fifo_wr_en_next = 1'b1;
          fifo_din_next   = hit_data;
          hit_cnt_next    = hit_cnt_reg + CNT_W'(1);
          to_cnt_next     = '0;
          if (hit_cnt_reg == NUM_HITS_C - CNT_W'(1)) begin
            ww_next    = NUM_HITS_C;
            state_next = ST_IDLE;
          end
        end else if (to_cnt_reg >= TO_LAST) begin
          wr_err_next = 1'b1;
          ww_next     = hit_cnt_reg;
          state_next  = ST_IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_reg == SETTLE_LAST) begin
`ifdef TDC_SEQ_HEADER_EN
          state_next = ST_HDR0;
`else
          state_next = ST_POP;
`endif
        end else begin
          settle_cnt_next = settle_cnt_reg + ST_W'(1);
        end
      end
`ifdef TDC_SEQ_HEADER_EN
      ST_HDR0: begin
        hdr_valid = 1'b1;
        hdr_data  = HDR_SYNC;
        if (tx_ready) state_next = ST_HDR1;
      end
      ST_HDR1: begin
        hdr_valid = 1'b1;
        hdr_data  = 8'(ww_reg);
        if (tx_ready) state_next = ST_POP;
      end
`endif
      ST_POP: begin
        if (rd_cnt_reg == ww_reg) begin
          state_next = ST_IDLE;
        end else if (fifo_empty) begin
          rd_err_next = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          fifo_rd_en = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        ser_load   = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (ser_done) begin
          rd_cnt_next = rd_cnt_reg + CNT_W'(1);
          state_next  = ST_POP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign fifo_wr_en      = fifo_wr_en_reg;
  assign fifo_din        = fifo_din_reg;
  assign led_write_stage = (state_reg == ST_WRITE);
  assign led_read_stage  = (state_reg == ST_SETTLE) || (state_reg == ST_HDR0) ||
                           (state_reg == ST_HDR1)   || (state_reg == ST_POP)  ||
                           (state_reg == ST_WAIT)   || (state_reg == ST_SEND);
  assign led_write_err   = wr_err_reg;
  assign led_read_err    = rd_err_reg;
  assign tx_valid        = hdr_valid | ser_valid;
  assign tx_data         = hdr_valid ? hdr_data : (ser_valid ? ser_data : 8'h00);

endmodule

// File: tb/tb_tdc_acq_sequencer.sv
// Scoreboard bench for tdc_acq_sequencer: random hits and UART back-pressure, with a FIFO
// model around the DUT and expected bytes derived from the accepted hit list.
`timescale 1ns/1ps
module tb_tdc_acq_sequencer;

  localparam int DATA_W      = 32;
  localparam int NUM_HITS    = 32;
  localparam int SETTLE_CYC  = 8;
  localparam int TIMEOUT_CYC = 200;
  localparam int NB          = DATA_W / 8;
  localparam int BIG         = 1 << 30;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start_write = 1'b0;
  logic              start_read = 1'b0;
  logic              hit_valid = 1'b0;
  logic [DATA_W-1:0] hit_data = '0;
  logic              fifo_full = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              tx_ready = 1'b1;
  logic              fifo_wr_en, fifo_rd_en, tx_valid;
  logic [DATA_W-1:0] fifo_din;
  logic [7:0]        tx_data;
  logic              led_write_stage, led_read_stage, led_write_err, led_read_err;

  tdc_acq_sequencer #(
    .DATA_W(DATA_W), .NUM_HITS(NUM_HITS), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_write(start_write), .start_read(start_read),
    .hit_valid(hit_valid), .hit_data(hit_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .led_write_stage(led_write_stage), .led_read_stage(led_read_stage),
    .led_write_err(led_write_err), .led_read_err(led_read_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_wr[$];
  logic [7:0]        exp_tx[$];
  logic [DATA_W-1:0] model_words[$];
  int                model_ww = 0;
  logic [DATA_W-1:0] fq[$];
  int                empty_limit = BIG;
  int                rd_count = 0;
  int                bytes_seen = 0;
  int                stall_cnt = 0;
  bit                rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd_empty();
    fifo_empty = (fq.size() == 0) || (rd_count >= empty_limit);
  endtask

  // Hit FIFO model: zero-latency flags, read data one cycle after fifo_rd_en.
  initial forever begin
    @(posedge clk);
    if (rst_n) begin
      if (fifo_rd_en) begin
        if (fq.size() > 0) fifo_dout <= fq.pop_front();
        else fifo_dout <= '0;
        rd_count++;
      end
      if (fifo_wr_en) fq.push_back(fifo_din);
    end
    #1 upd_empty();
  end

  // UART back-pressure.
  initial forever begin
    @(posedge clk);
    #1;
    if (stall_cnt > 0) begin
      tx_ready = 1'b0;
      stall_cnt--;
    end else begin
      tx_ready = rand_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes the FIFO or hands over a byte.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("tx_valid held", tx_valid, 1);
        chk("tx_data held", tx_data, prev_data);
      end
      if (fifo_wr_en) begin
        if (exp_wr.size() == 0) chk("unexpected fifo write", fifo_wr_en, 0);
        else chk("fifo_din", fifo_din, exp_wr.pop_front());
        chk("wr_en/rd_en exclusive", fifo_rd_en, 0);
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) chk("unexpected tx byte", tx_valid, 0);
        else chk("tx byte", tx_data, exp_tx.pop_front());
        bytes_seen++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, " fifo_wr_en"}, fifo_wr_en, 0);
    chk({tag, " fifo_din"}, fifo_din, 0);
    chk({tag, " fifo_rd_en"}, fifo_rd_en, 0);
    chk({tag, " tx_valid"}, tx_valid, 0);
    chk({tag, " tx_data"}, tx_data, 0);
    chk({tag, " led_write_stage"}, led_write_stage, 0);
    chk({tag, " led_read_stage"}, led_read_stage, 0);
    chk({tag, " led_write_err"}, led_write_err, 0);
    chk({tag, " led_read_err"}, led_read_err, 0);
  endtask

  // spacing 0 = fixed 40 cycles; special = word0 0x1234 plus start_read pulses that must be ignored.
  task automatic run_write(input int n_send, input int full_at, input int spacing, input bit special);
    bit                exp_err;
    int                gap;
    int                waited;
    logic [DATA_W-1:0] w;
    exp_err = 1'b0;
    model_words.delete();
    exp_wr.delete();
    fq.delete();
    rd_count = 0;
    empty_limit = BIG;
    upd_empty();
    start_write = 1'b1;
    start_read  = special;
    tick();
    start_write = 1'b0;
    start_read  = 1'b0;
    for (int i = 1; i <= n_send; i++) begin
      gap = (spacing == 0) ? 40 : int'($urandom_range(1, spacing));
      repeat (gap - 1) tick();
      w = (special && i == 1) ? DATA_W'(32'h0000_1234) : DATA_W'($urandom);
      hit_valid  = 1'b1;
      hit_data   = w;
      fifo_full  = (i == full_at);
      start_read = special && (i == 3);
      tick();
      hit_valid  = 1'b0;
      fifo_full  = 1'b0;
      start_read = 1'b0;
      if (i == full_at) begin
        exp_err = 1'b1;
        break;
      end
      exp_wr.push_back(w);
      model_words.push_back(w);
    end
    model_ww = model_words.size();
    if (model_ww < NUM_HITS) exp_err = 1'b1;
    waited = 0;
    while (led_write_stage && waited < TIMEOUT_CYC + 100) begin
      tick();
      waited++;
    end
    chk("write stage ended", led_write_stage, 0);
    tick();
    tick();
    chk("led_write_err", led_write_err, exp_err);
    chk("fifo writes outstanding", exp_wr.size(), 0);
    chk("fifo word count", fq.size(), model_ww);
    $display("write run: sent %0d hits, words_written %0d, write_err %0b", n_send, model_ww, led_write_err);
  endtask

  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async reset");
    exp_tx.delete();
    exp_wr.delete();
    fq.delete();
    model_words.delete();
    model_ww = 0;
    stall_cnt = 0;
    rand_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post reset read stage", led_read_stage, 0);
    $display("reset asserted mid-read after %0d bytes", bytes_seen);
  endtask

  task automatic run_read(input int empty_after, input bit rnd, input int stall_at, input int reset_at);
    int                n_words, n_bytes, waited;
    bit                exp_err, stalled;
    logic [DATA_W-1:0] w;
    exp_tx.delete();
    bytes_seen = 0;
    rd_count = 0;
    rand_ready = rnd;
    empty_limit = empty_after;
    upd_empty();
`ifdef TDC_SEQ_HEADER_EN
    exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'(model_ww));
`endif
    n_words = (model_ww < empty_after) ? model_ww : empty_after;
    exp_err = (empty_after < model_ww);
    for (int k = 0; k < n_words; k++) begin
      w = model_words[k];
      for (int b = 0; b < NB; b++) exp_tx.push_back(w[DATA_W-1-8*b -: 8]);
    end
    n_bytes = exp_tx.size();
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    waited = 0;
    stalled = 1'b0;
    while (led_read_stage && waited < 20000) begin
      if (stall_at >= 0 && !stalled && bytes_seen >= stall_at) begin
        stall_cnt = 50;
        stalled = 1'b1;
      end
      if (reset_at >= 0 && bytes_seen >= reset_at) begin
        do_reset();
        return;
      end
      tick();
      waited++;
    end
    chk("read stage ended", led_read_stage, 0);
    chk("bytes sent", bytes_seen, n_bytes);
    chk("bytes outstanding", exp_tx.size(), 0);
    chk("led_read_err", led_read_err, exp_err);
    chk("tx_valid idle", tx_valid, 0);
    rand_ready = 1'b0;
    $display("read run: %0d bytes sent (expected %0d), read_err %0b", bytes_seen, n_bytes, led_read_err);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    run_write(NUM_HITS, 0, 0, 1'b1);
    run_read(BIG, 1'b0, -1, -1);
    run_write(NUM_HITS, 0, 8, 1'b0);
    run_read(BIG, 1'b1, 6, -1);
    run_write(NUM_HITS, 10, 4, 1'b0);
    run_read(BIG, 1'b0, -1, -1);
    run_write(NUM_HITS, 0, 3, 1'b0);
    run_read(5, 1'b1, -1, -1);
    run_write(5, 0, 6, 1'b0);
    run_read(BIG, 1'b0, -1, -1);
    run_write(NUM_HITS, 0, 2, 1'b0);
    run_read(BIG, 1'b0, -1, 10);
    run_read(BIG, 1'b0, -1, -1);
    run_write(NUM_HITS, 0, 2, 1'b0);
    run_read(BIG, 1'b1, -1, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
